// File: rtl/seq_detect_prog_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
// The reset defaults reproduce the legacy fixed "101" overlapping detector.
package seq_det_pkg;

   localparam int unsigned CMP_W          = 32;
   localparam int unsigned LEGACY_PATTERN = 'b101;
   localparam int unsigned LEGACY_LEN     = 3;
   localparam bit          LEGACY_OVERLAP = 1'b1;

   typedef enum logic {
      OVL_RESTART = 1'b0,
      OVL_ALLOW   = 1'b1
   } overlap_e;

   function automatic int unsigned len_w(int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   // Equality over the low 'len' bits only; everything above is ignored.
   function automatic logic masked_eq(logic [CMP_W-1:0] a, logic [CMP_W-1:0] b,
                                      int unsigned len);
      logic eq;
      eq = 1'b1;
      for (int unsigned i = 0; i < CMP_W; i++) begin
         if (i < len && a[i] != b[i]) eq = 1'b0;
      end
      return eq;
   endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Configuration, serial-input and match-reporting signals of seq_detect_prog.
interface seq_detect_prog_if #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 16
);
   import seq_det_pkg::*;

   localparam int unsigned LEN_W = len_w(MAX_LEN);

   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cfg_err;
   logic               in_valid;
   logic               in_bit;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_clr;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, cnt_clr,
      input  cfg_err, match, match_cnt
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, cnt_clr,
      output cfg_err, match, match_cnt
   );

endinterface

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable Moore serial pattern detector with registered match pulse
// and saturating match counter.
module seq_detect_prog
   import seq_det_pkg::*;
#(
   parameter int unsigned        MAX_LEN     = 8,
   parameter int unsigned        CNT_W       = 16,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(LEGACY_PATTERN),
   parameter int unsigned        DEF_LEN     = LEGACY_LEN,
   parameter bit                 DEF_OVERLAP = LEGACY_OVERLAP
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_detect_prog_if.slave bus
);

   localparam int unsigned LEN_W = len_w(MAX_LEN);

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   overlap_e           ovl_q;
   // The oldest bit of a full window is never compared again, so only MAX_LEN-1 bits persist.
   logic [MAX_LEN-2:0] hist_q;
   logic [MAX_LEN-1:0] hist_d;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_inc;
   logic               match_q;
   logic               err_q;
   logic               accept;
   logic               hit;
   logic               cfg_ok;
   logic [CNT_W-1:0]   cnt;

   always_comb begin
      accept   = bus.in_valid & ~bus.cfg_we;
      hist_d   = {hist_q, bus.in_bit};
      fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
      hit      = accept && (fill_inc >= len_q) &&
                 masked_eq(CMP_W'(hist_d), CMP_W'(pat_q), CMP_W'(len_q));
      cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q   <= DEF_PATTERN;
         len_q   <= LEN_W'(DEF_LEN);
         ovl_q   <= overlap_e'(DEF_OVERLAP);
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         match_q <= hit;
         err_q   <= bus.cfg_we & ~cfg_ok;
         if (bus.cfg_we) begin
            if (cfg_ok) begin
               pat_q  <= bus.cfg_pattern;
               len_q  <= bus.cfg_len;
               ovl_q  <= overlap_e'(bus.cfg_overlap);
               hist_q <= '0;
               fill_q <= '0;
            end
         end else if (bus.in_valid) begin
            hist_q <= hist_d[MAX_LEN-2:0];
            fill_q <= (hit && ovl_q == OVL_RESTART) ? '0 : fill_inc;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (hit),
      .clr_i (bus.cnt_clr),
      .cnt_o (cnt)
   );

   assign bus.match     = match_q;
   assign bus.cfg_err   = err_q;
   assign bus.match_cnt = cnt;

endmodule
